// File: rtl/scp_mon_pkg.sv
// Shared types for the store-result monitor: verdict FSM states, failure codes
// and the packing of one log entry.
package scp_mon_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BAD_DATA = 2'd1,
        BAD_ADR  = 2'd2,
        TIMEOUT  = 2'd3
    } fail_code_t;

    localparam int LOG_WIDTH = 64;

    function automatic logic [LOG_WIDTH-1:0] pack_entry(input logic [31:0] adr,
                                                        input logic [31:0] data);
        return {adr, data};
    endfunction

endpackage

// File: rtl/store_result_monitor_fifo.sv
// First-word-fall-through synchronous FIFO; pushes to a full FIFO are dropped
// even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/store_result_monitor.sv
// Watches the processor's store bus, latches a pass/fail verdict and logs every
// store accepted while running into a FIFO drained over a valid/ready stream.
module store_result_monitor
    import scp_mon_pkg::*;
#(
    parameter logic [31:0] DONE_ADR    = 32'd84,
    parameter logic [31:0] EXPECT_DATA = 32'd28,
    parameter logic [31:0] SCRATCH_ADR = 32'd80,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        overflow
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    mon_state_t           state_q, state_d;
    fail_code_t           code_q, code_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 overflow_q, overflow_d;
    logic                 pass_q, fail_q, done_q;
    logic                 store_s;
    logic                 full_s, empty_s;
    logic [LOG_WIDTH-1:0] head_s;

    assign store_s = mem_write && (state_q == RUN);

    sync_fifo #(
        .WIDTH(LOG_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_log_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (store_s),
        .din   (pack_entry(data_adr, write_data)),
        .pop   (log_ready),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign log_valid = !empty_s;
    assign log_adr   = head_s[63:32];
    assign log_data  = head_s[31:0];

    // Verdict rules; a store on the timeout cycle takes precedence over timeout.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        timer_d    = timer_q;
        overflow_d = overflow_q | (store_s & full_s);
        case (state_q)
            RUN: begin
                if (mem_write) begin
                    timer_d = '0;
                    if (data_adr == DONE_ADR) begin
                        if (write_data == EXPECT_DATA) begin
                            state_d = PASS;
                        end else begin
                            state_d = FAIL;
                            code_d  = BAD_DATA;
                        end
                    end else if (data_adr == SCRATCH_ADR) begin
                        state_d = RUN;
                    end else begin
                        state_d = FAIL;
                        code_d  = BAD_ADR;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = FAIL;
                    code_d  = TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PASS:    state_d = PASS;
            FAIL:    state_d = FAIL;
            default: begin
                state_d = FAIL;
                code_d  = NONE;
            end
        endcase
    end

    // State, timer and registered verdict outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            code_q     <= NONE;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            pass_q     <= (state_d == PASS);
            fail_q     <= (state_d == FAIL);
            done_q     <= (state_d == PASS) || (state_d == FAIL);
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_store_result_monitor.sv
// Bench for store_result_monitor: directed scenarios plus randomized traffic
// checked against a queue-based model of the verdict and logging rules.
module tb_store_result_monitor;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        done, pass, fail, log_valid, log_ready, overflow;
    logic [1:0]  fail_code;
    logic [31:0] log_adr, log_data;

    int vectors    = 0;
    int miscompares = 0;

    // model: 0 running, 1 passed, 2 failed
    logic [63:0] mq[$];
    int          m_state;
    logic [1:0]  m_code;
    bit          m_ovf;
    int          m_idle;

    always #5 clk = ~clk;

    store_result_monitor #(
        .DONE_ADR   (32'd84),
        .EXPECT_DATA(32'd28),
        .SCRATCH_ADR(32'd80),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .data_adr  (data_adr),
        .write_data(write_data),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_code (fail_code),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_adr   (log_adr),
        .log_data  (log_data),
        .overflow  (overflow)
    );

    task automatic step(input logic rst, input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        bit do_pop, do_push;
        reset = rst; mem_write = mw; data_adr = a; write_data = d; log_ready = rdy;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_state = 0; m_code = 2'd0; m_ovf = 1'b0; m_idle = 0;
        end else begin
            do_pop  = rdy && (mq.size() > 0);
            do_push = mw && (m_state == 0);
            if (do_push && mq.size() == DEPTH) begin
                m_ovf = 1'b1;
                do_push = 1'b0;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({a, d});
            if (m_state == 0) begin
                if (mw) begin
                    m_idle = 0;
                    if (a == 32'd84) begin
                        if (d == 32'd28) m_state = 1;
                        else begin m_state = 2; m_code = 2'd1; end
                    end else if (a != 32'd80) begin
                        m_state = 2; m_code = 2'd2;
                    end
                end else if (m_idle == TMO - 1) begin
                    m_state = 2; m_code = 2'd3;
                end else begin
                    m_idle++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd88, 32'd1, 1'b1);
        vectors++;
        if ({done, pass, fail, fail_code, overflow, log_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b required 0000000",
                     {done, pass, fail, fail_code, overflow, log_valid});
        end
    endtask

    task automatic test_pass_program();
        logic [31:0] ed [3] = '{32'd7, 32'd11, 32'd28};
        logic [31:0] ea [3] = '{32'd80, 32'd80, 32'd84};
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd80, 32'd7, 1'b0);
        vectors++;
        if (pass !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_early got pass=%b done=%b required 0 0", pass, done);
        end
        step(1'b0, 1'b1, 32'd80, 32'd11, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd28, 1'b0);
        vectors++;
        if ({pass, fail, done, fail_code} !== 5'b10100) begin
            miscompares++;
            $display("FAIL pass_verdict got p/f/d/code=%b required 10100",
                     {pass, fail, done, fail_code});
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (log_valid !== 1'b1 || log_adr !== ea[i] || log_data !== ed[i]) begin
                miscompares++;
                $display("FAIL pass_drain%0d got v=%b %0d/%0d required 1 %0d/%0d",
                         i, log_valid, log_adr, log_data, ea[i], ed[i]);
            end
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        vectors++;
        if (log_valid !== 1'b0 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_empty got v=%b pass=%b required 0 1", log_valid, pass);
        end
    endtask

    task automatic test_bad_data();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd27, 1'b0);
        vectors++;
        if ({pass, fail, done, fail_code} !== 5'b01101) begin
            miscompares++;
            $display("FAIL bad_data got p/f/d/code=%b required 01101",
                     {pass, fail, done, fail_code});
        end
        step(1'b0, 1'b1, 32'd84, 32'd28, 1'b0);
        vectors++;
        if ({pass, fail, done, fail_code} !== 5'b01101 ||
            log_adr !== 32'd84 || log_data !== 32'd27) begin
            miscompares++;
            $display("FAIL bad_data_sticky got p/f/d/code=%b head=%0d/%0d required 01101 84/27",
                     {pass, fail, done, fail_code}, log_adr, log_data);
        end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_data_nolog got v=%b required 0", log_valid);
        end
    endtask

    task automatic test_bad_adr_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd80, 32'd5, 1'b0);
        step(1'b0, 1'b1, 32'd80, 32'd6, 1'b0);
        step(1'b0, 1'b1, 32'd88, 32'd28, 1'b0);
        vectors++;
        if ({fail, fail_code} !== 3'b110 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_adr got fail/code=%b pass=%b required 110 0",
                     {fail, fail_code}, pass);
        end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        vectors++;
        if (log_valid !== 1'b1 || log_data !== 32'd6) begin
            miscompares++;
            $display("FAIL bad_adr_drain got v=%b data=%0d required 1 6", log_valid, log_data);
        end
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        vectors++;
        if ({done, pass, fail, fail_code, overflow, log_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL midrain_reset got %b required 0000000",
                     {done, pass, fail, fail_code, overflow, log_valid});
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 32'd80, 32'(i + 100), 1'b0);
            if (i == 7) begin
                vectors++;
                if (overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_early got %b required 0", overflow);
                end
            end
        end
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set got %b required 1", overflow);
        end
        step(1'b0, 1'b1, 32'd84, 32'd28, 1'b1);
        vectors++;
        if (pass !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_pass got %b required 1", pass);
        end
        for (int i = 1; i < 8; i++) begin
            vectors++;
            if (log_valid !== 1'b1 || log_adr !== 32'd80 || log_data !== 32'(i + 100)) begin
                miscompares++;
                $display("FAIL ovf_drain%0d got v=%b %0d/%0d required 1 80/%0d",
                         i, log_valid, log_adr, log_data, i + 100);
            end
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        vectors++;
        if (log_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_end got v=%b ovf=%b required 0 1", log_valid, overflow);
        end
    endtask

    task automatic test_timeout();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        vectors++;
        if (fail !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_early got %b required 0", fail);
        end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        vectors++;
        if ({fail, done, fail_code} !== 4'b1111) begin
            miscompares++;
            $display("FAIL tmo_verdict got f/d/code=%b required 1111", {fail, done, fail_code});
        end
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd28, 1'b0);
        vectors++;
        if ({pass, fail, fail_code} !== 4'b1000) begin
            miscompares++;
            $display("FAIL tmo_store_wins got p/f/code=%b required 1000", {pass, fail, fail_code});
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] exp[$];
        int n = 0;
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1, 32'd80, 32'(n), 1'b0); exp.push_back(32'(n)); n++; end
        for (int i = 0; i < 3; i++) begin step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1); void'(exp.pop_front()); end
        for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1, 32'd80, 32'(n), 1'b0); exp.push_back(32'(n)); n++; end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'd80, 32'(n), 1'b1);
            void'(exp.pop_front()); exp.push_back(32'(n)); n++;
        end
        vectors++;
        if (overflow !== 1'b0 || exp.size() != 7 || mq.size() != 7) begin
            miscompares++;
            $display("FAIL wrap_no_ovf got ovf=%b required 0", overflow);
        end
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (log_valid !== 1'b1 || log_data !== exp[i]) begin
                miscompares++;
                $display("FAIL wrap_order%0d got v=%b data=%0d required 1 %0d",
                         i, log_valid, log_data, exp[i]);
            end
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        vectors++;
        if (log_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_empty got v=%b required 0", log_valid);
        end
    endtask

    task automatic test_random();
        logic        mw, rdy;
        logic [31:0] a, d;
        int          r;
        for (int round = 0; round < 6; round++) begin
            step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            for (int c = 0; c < 60; c++) begin
                mw = ($urandom_range(0, 2) != 0);
                r  = $urandom_range(0, 19);
                a  = (r < 15) ? 32'd80 : (r < 18) ? 32'd84 : $urandom;
                d  = ($urandom_range(0, 1) != 0) ? 32'd28 : $urandom;
                rdy = ($urandom_range(0, 3) == 0);
                step(1'b0, mw, a, d, rdy);
                vectors++;
                if (pass !== (m_state == 1) || fail !== (m_state == 2) ||
                    done !== (m_state != 0) || fail_code !== m_code ||
                    overflow !== m_ovf || log_valid !== (mq.size() > 0)) begin
                    miscompares++;
                    $display("FAIL rand_status r%0d c%0d got p/f/d/code/ovf/v=%b required %b",
                             round, c, {pass, fail, done, fail_code, overflow, log_valid},
                             {m_state == 1, m_state == 2, m_state != 0, m_code, m_ovf, mq.size() > 0});
                end
                if (mq.size() > 0) begin
                    vectors++;
                    if ({log_adr, log_data} !== mq[0]) begin
                        miscompares++;
                        $display("FAIL rand_head r%0d c%0d got %h required %h",
                                 round, c, {log_adr, log_data}, mq[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; mem_write = 1'b0; data_adr = 32'd0; write_data = 32'd0; log_ready = 1'b0;
        test_reset();
        test_pass_program();
        test_bad_data();
        test_bad_adr_reset();
        test_overflow();
        test_timeout();
        test_back_to_back_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
